fault_campaign_ctrl: RTL
========================

# fault_campaign_ctrl

Sequencing controller that drives a fault-injection campaign against the two-level test circuit (y = sig1 ^ sig2, sig1 = a | b, sig2 = e | ~f). It applies all 16 stimulus patterns on {a,b,e,f}, first fault-free and then with each of six single faults forced on sig1 or sig2, samples the circuit's y, and compares it against an internal golden model. Per-fault detection results and mismatch events are reported for the campaign log. It is the driving end of the injection path; the circuit under test only observes and logs.

## Interface
- HOLD_CYCLES, 1, settle cycles per pattern before sampling y_dut (legal 1..15)
- STOP_ON_DETECT, 1, 1: advance to next fault on first detection; 0: run all 16 patterns per fault
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  campaign start pulse; ignored while busy
- y_dut  in  1  output of circuit under test
- stim  out  4  {a,b,e,f}; a = stim[3], f = stim[0]
- inj_en  out  1  fault forcing enable
- inj_site  out  1  0 = sig1, 1 = sig2
- inj_type  out  2  0 = stuck-at-0, 1 = stuck-at-1, 2 = bit-flip, 3 = reserved (never driven)
- busy  out  1  campaign in progress
- done  out  1  one-cycle pulse at campaign end
- campaign_err  out  1  baseline mismatch seen; sticky until next start
- mis_valid  out  1  one-cycle pulse per detected mismatch
- mis_fault  out  3  fault index of mismatch (7 = baseline)
- mis_pattern  out  4  stim value at mismatch
- detected_mask  out  6  bit i set when fault i detected

## Operation
- Phases: baseline (fault index 7, inj_en=0), then faults 0..5; inj_site = idx/3, inj_type = idx%3.
- FSM: IDLE -> APPLY -> SAMPLE -> (APPLY | NEXT) -> ... -> DONE -> IDLE.
- IDLE: outputs static; start=1 clears detected_mask, campaign_err, pattern counter; enter APPLY with phase=baseline, pattern=0.
- APPLY: drive stim=pattern, inj_* per phase; hold HOLD_CYCLES cycles.
- SAMPLE: compare y_dut to golden(stim) computed fault-free. Mismatch: mis_valid=1 with mis_fault/mis_pattern; in fault phases set detected_mask[idx].
- Baseline mismatch: set campaign_err, abort directly to DONE (no fault phases).
- After SAMPLE: if pattern==15, or (STOP_ON_DETECT and detected in this phase) -> NEXT; else pattern+1, APPLY.
- NEXT: pattern=0; phase advances baseline->0->...->5; after 5 -> DONE.
- DONE: done=1 for one cycle, inj_en=0, busy=0 next cycle; IDLE.
- Pattern counter 4-bit, never wraps past 15 within a phase.

## Timing
- Reset values: stim=0, inj_en=0, inj_site=0, inj_type=0, busy=0, done=0, campaign_err=0, mis_valid=0, mis_fault=0, mis_pattern=0, detected_mask=0; FSM=IDLE.
- start sampled at edge k in IDLE -> busy=1 and first stim valid after edge k.
- Each pattern occupies HOLD_CYCLES+1 cycles; y_dut sampled at the SAMPLE cycle edge.
- NEXT is one cycle with inj_en=0; full campaign without early stop: 7*16*(HOLD_CYCLES+1) + 6 + 1 cycles.
- mis_valid asserted the cycle after SAMPLE (registered), coincident with updated detected_mask.
- Reset mid-campaign: all outputs return to reset values immediately (asynchronous); no done pulse.
- start coincident with done cycle: ignored.

## Structure
- Package fault_pkg: fault_type enum (SA0, SA1, FLIP), site constants (SITE_SIG1, SITE_SIG2), BASELINE_IDX=7, N_FAULTS=6, fsm state enum.
- Sub-module fault_ref_model: combinational golden y from stim (and optional fault) — reused by the bench as scoreboard.
- Controller FSM, pattern counter, hold counter in fault_campaign_ctrl.

## Test plan
- Correct DUT honouring injection, HOLD_CYCLES=1, STOP_ON_DETECT=1 -> detected_mask=6'b111111; first mis_pattern per fault: 0:4'h4, 1:0, 2:0, 3:0, 4:4'h1, 5:0; campaign_err=0; done once.
- DUT ignoring inj_en -> detected_mask=0, no mis_valid, done after 7*16*2+7 cycles from start.
- DUT output inverted -> mis_valid at baseline pattern 0 (mis_fault=7), campaign_err=1, done next; inj_en never asserted.
- STOP_ON_DETECT=0, correct DUT -> all 16 patterns per fault; sig1 SA0 mismatches exactly at patterns 4..15.
- Assert rst_n low mid-fault-3 -> outputs at reset values same cycle; new start runs full campaign with clean mask.
- start pulsed while busy -> ignored; campaign timing unchanged.

Source files
------------

// File: rtl/fault_pkg.sv
// Shared definitions for the fault-injection campaign controller.
// Holds fault-type and FSM enums, site constants, the mismatch record and
// helpers that map a fault index onto its injection site and fault type.
package fault_pkg;

   localparam int unsigned STIM_W     = 4;
   localparam int unsigned IDX_W      = 3;
   localparam int unsigned HOLD_W     = 4;
   localparam int unsigned N_FAULTS   = 6;
   localparam int unsigned N_PATTERNS = 16;

   localparam logic [IDX_W-1:0] BASELINE_IDX = 3'd7;

   localparam logic SITE_SIG1 = 1'b0;
   localparam logic SITE_SIG2 = 1'b1;

   typedef enum logic [1:0] {
      SA0  = 2'd0,
      SA1  = 2'd1,
      FLIP = 2'd2
   } fault_type_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPLY  = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_NEXT   = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   // One logged mismatch event.
   typedef struct packed {
      logic [IDX_W-1:0]  fault;
      logic [STIM_W-1:0] pattern;
   } mis_rec_t;

   // Faults 0..2 live on sig1, 3..5 on sig2.
   function automatic logic fault_site(input logic [IDX_W-1:0] idx);
      return (idx >= 3'd3) ? SITE_SIG2 : SITE_SIG1;
   endfunction

   // SA0, SA1, FLIP repeat for each site.
   function automatic logic [1:0] fault_kind(input logic [IDX_W-1:0] idx);
      logic [IDX_W-1:0] r;
      r = (idx >= 3'd3) ? IDX_W'(idx - 3'd3) : idx;
      return r[1:0];
   endfunction

   // Value of a node after the given fault is forced onto it.
   function automatic logic apply_fault(input logic v, input fault_type_e t);
      case (t)
         SA0:     return 1'b0;
         SA1:     return 1'b1;
         FLIP:    return ~v;
         default: return v;
      endcase
   endfunction

endpackage

// File: rtl/fault_ref_model.sv
// Combinational model of the two-level test circuit:
//   sig1 = a | b, sig2 = e | ~f, y = sig1 ^ sig2, with an optional forced fault.
// Ports: stim {a,b,e,f}; flt_en/flt_site/flt_type select the fault; y_c result.
module fault_ref_model
   import fault_pkg::*;
(
   input  logic [STIM_W-1:0] stim,
   input  logic              flt_en,
   input  logic              flt_site,
   input  fault_type_e       flt_type,
   output logic              y_c
);

   logic sig1;
   logic sig2;
   logic sig1_f;
   logic sig2_f;

   // Nominal nodes, then the fault overlay on the selected site.
   always_comb begin
      sig1   = stim[3] | stim[2];
      sig2   = stim[1] | ~stim[0];
      sig1_f = sig1;
      sig2_f = sig2;
      if (flt_en) begin
         if (flt_site == SITE_SIG1) sig1_f = apply_fault(sig1, flt_type);
         else                       sig2_f = apply_fault(sig2, flt_type);
      end
      y_c = sig1_f ^ sig2_f;
   end

endmodule

// File: rtl/fault_campaign_ctrl.sv
// Fault-injection campaign sequencer. Runs all 16 patterns fault-free
// (baseline), then under each of six single faults, compares y_dut against
// the fault-free golden value and logs mismatches / per-fault detection.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             campaign start pulse (honoured only when idle)
//   y_dut             sampled output of the circuit under test
//   stim              applied pattern {a,b,e,f}
//   inj_en/site/type  fault forcing controls toward the circuit
//   busy, done        campaign running / one-cycle end pulse
//   campaign_err      sticky baseline-mismatch flag
//   mis_valid/fault/pattern  mismatch event log
//   detected_mask     per-fault detection bits
module fault_campaign_ctrl
   import fault_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES    = 1,
   parameter bit          STOP_ON_DETECT = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                y_dut,
   output logic [STIM_W-1:0]   stim,
   output logic                inj_en,
   output logic                inj_site,
   output logic [1:0]          inj_type,
   output logic                busy,
   output logic                done,
   output logic                campaign_err,
   output logic                mis_valid,
   output logic [IDX_W-1:0]    mis_fault,
   output logic [STIM_W-1:0]   mis_pattern,
   output logic [N_FAULTS-1:0] detected_mask
);

   state_e               state, state_d;
   logic [STIM_W-1:0]    pattern, pattern_d;
   logic [HOLD_W-1:0]    hold_cnt, hold_d;
   logic [IDX_W-1:0]     phase, phase_d;
   logic                 inj_en_d, inj_site_d;
   logic [1:0]           inj_type_d;
   logic                 busy_d, done_d, err_d, mis_valid_d;
   mis_rec_t             mis, mis_d;
   logic [N_FAULTS-1:0]  mask_d;
   logic                 golden_c;
   logic                 mismatch_c;
   logic                 last_phase_c;

   // Fault-free expectation for the pattern currently applied.
   fault_ref_model u_golden (
      .stim     (pattern),
      .flt_en   (1'b0),
      .flt_site (SITE_SIG1),
      .flt_type (SA0),
      .y_c      (golden_c)
   );

   assign stim        = pattern;
   assign mis_fault   = mis.fault;
   assign mis_pattern = mis.pattern;

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         pattern       <= '0;
         hold_cnt      <= '0;
         phase         <= '0;
         inj_en        <= 1'b0;
         inj_site      <= 1'b0;
         inj_type      <= 2'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
         campaign_err  <= 1'b0;
         mis_valid     <= 1'b0;
         mis           <= '0;
         detected_mask <= '0;
      end else begin
         state         <= state_d;
         pattern       <= pattern_d;
         hold_cnt      <= hold_d;
         phase         <= phase_d;
         inj_en        <= inj_en_d;
         inj_site      <= inj_site_d;
         inj_type      <= inj_type_d;
         busy          <= busy_d;
         done          <= done_d;
         campaign_err  <= err_d;
         mis_valid     <= mis_valid_d;
         mis           <= mis_d;
         detected_mask <= mask_d;
      end
   end

   assign mismatch_c   = (y_dut != golden_c);
   assign last_phase_c = (phase == IDX_W'(N_FAULTS - 1));

   // Next-state and next-output logic.
   always_comb begin
      logic [IDX_W-1:0] nxt_phase;
      state_d     = state;
      pattern_d   = pattern;
      hold_d      = hold_cnt;
      phase_d     = phase;
      inj_en_d    = inj_en;
      inj_site_d  = inj_site;
      inj_type_d  = inj_type;
      busy_d      = busy;
      done_d      = 1'b0;
      err_d       = campaign_err;
      mis_valid_d = 1'b0;
      mis_d       = mis;
      mask_d      = detected_mask;
      nxt_phase   = '0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_APPLY;
               pattern_d  = '0;
               hold_d     = '0;
               phase_d    = BASELINE_IDX;
               inj_en_d   = 1'b0;
               inj_site_d = 1'b0;
               inj_type_d = 2'd0;
               busy_d     = 1'b1;
               err_d      = 1'b0;
               mask_d     = '0;
            end
         end

         ST_APPLY: begin
            if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) state_d = ST_SAMPLE;
            else                                      hold_d  = HOLD_W'(hold_cnt + 4'd1);
         end

         ST_SAMPLE: begin
            hold_d = '0;
            if (mismatch_c) begin
               mis_valid_d   = 1'b1;
               mis_d.fault   = phase;
               mis_d.pattern = pattern;
               if (phase == BASELINE_IDX) err_d = 1'b1;
               else                       mask_d[phase] = 1'b1;
            end
            // A broken baseline makes fault results meaningless: abort.
            if (mismatch_c && (phase == BASELINE_IDX)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else if ((pattern == 4'hF) || (STOP_ON_DETECT && mismatch_c)) begin
               inj_en_d   = 1'b0;
               inj_site_d = 1'b0;
               inj_type_d = 2'd0;
               pattern_d  = '0;
               if (last_phase_c) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_NEXT;
               end
            end else begin
               pattern_d = STIM_W'(pattern + 4'd1);
               state_d   = ST_APPLY;
            end
         end

         ST_NEXT: begin
            nxt_phase  = (phase == BASELINE_IDX) ? 3'd0 : IDX_W'(phase + 3'd1);
            phase_d    = nxt_phase;
            state_d    = ST_APPLY;
            pattern_d  = '0;
            hold_d     = '0;
            inj_en_d   = 1'b1;
            inj_site_d = fault_site(nxt_phase);
            inj_type_d = fault_kind(nxt_phase);
         end

         ST_DONE: begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            inj_en_d   = 1'b0;
            inj_site_d = 1'b0;
            inj_type_d = 2'd0;
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule
